// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient reload controller.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RELOAD,
    CONFIG
  } state_e;

  localparam int unsigned COEFF_W_DEF = 16;

  localparam int unsigned ERR_TLAST   = 0;
  localparam int unsigned ERR_WR_BUSY = 1;
  localparam int unsigned ERR_REQ_OVR = 2;
  localparam int unsigned ERR_TIMEOUT = 3;

  localparam logic [7:0] CONFIG_WORD = 8'h00;

endpackage

// File: rtl/fir_coeff_buf.sv
// Tap buffer: NUM_TAPS x COEFF_W simple dual-port RAM, synchronous write, registered read.
module fir_coeff_buf #(
  parameter  int unsigned NUM_TAPS = 21,
  parameter  int unsigned COEFF_W  = 16,
  localparam int unsigned ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [COEFF_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [COEFF_W-1:0] rd_data_o
);

  logic [COEFF_W-1:0] mem_q [NUM_TAPS];
  logic [COEFF_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_coeff_reload_ctrl.sv
// Run-time coefficient reload sequencer: gate, drain, stream taps, send config, ungate.
// Optional stall timeout is enabled by defining FIR_RELOAD_TIMEOUT_EN.
module fir_coeff_reload_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_TAPS       = 21,
  parameter  int unsigned COEFF_W        = COEFF_W_DEF,
  parameter  int unsigned DRAIN_CYCLES   = 64,
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ADDR_W         = $clog2(NUM_TAPS)
) (
  input  logic               clkfir,
  input  logic               reset,
  input  logic               coef_wr_en,
  input  logic [ADDR_W-1:0]  coef_wr_addr,
  input  logic [COEFF_W-1:0] coef_wr_data,
  input  logic               reload_req,
  input  logic               err_clr,
  output logic               reload_tvalid,
  input  logic               reload_tready,
  output logic               reload_tlast,
  output logic [COEFF_W-1:0] reload_tdata,
  output logic               config_tvalid,
  input  logic               config_tready,
  output logic [7:0]         config_tdata,
  input  logic               evt_tlast_miss,
  input  logic               evt_tlast_unex,
  output logic               data_gate,
  output logic               busy,
  output logic               done,
  output logic [3:0]         err_flags
);

  localparam int unsigned IDX_W   = ADDR_W + 1;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDX_W-1:0]   NUM_TAPS_I = IDX_W'(NUM_TAPS);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_TAPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   ld_idx_q, ld_idx_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic [COEFF_W-1:0] tdata_q, tdata_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               gate_q, gate_d;
  logic               done_q, done_d;
  logic [3:0]         err_q, err_d, err_set;
  logic               timeout;

  logic               buf_wr_en;
  logic [ADDR_W-1:0]  buf_rd_addr;
  logic [COEFF_W-1:0] buf_rd_data;

  assign busy      = (state_q != IDLE);
  assign buf_wr_en = coef_wr_en && !busy && ({1'b0, coef_wr_addr} < NUM_TAPS_I);
  // Reading at the next-state index keeps buf_rd_data == tap[ld_idx_q] every cycle,
  // so the output register can reload on the same edge a beat completes.
  assign buf_rd_addr = (ld_idx_d < NUM_TAPS_I) ? ld_idx_d[ADDR_W-1:0] : '0;

  fir_coeff_buf #(
    .NUM_TAPS (NUM_TAPS),
    .COEFF_W  (COEFF_W)
  ) u_buf (
    .clk_i     (clkfir),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (coef_wr_addr),
    .wr_data_i (coef_wr_data),
    .rd_addr_i (buf_rd_addr),
    .rd_data_o (buf_rd_data)
  );

`ifdef FIR_RELOAD_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stalled;

  always_comb begin
    stalled = ((state_q == RELOAD) && tvalid_q && !reload_tready) ||
              ((state_q == CONFIG) && cfg_valid_q && !config_tready);
    timeout = stalled && (stall_q == STALL_LAST);
    stall_d = (stalled && !timeout) ? stall_q + 1'b1 : '0;
  end

  always_ff @(posedge clkfir) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_idx_d    = ld_idx_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    cfg_valid_d = cfg_valid_q;
    gate_d      = gate_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ld_idx_d = '0;
        if (reload_req) begin
          state_d = DRAIN;
          cnt_d   = '0;
          gate_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = RELOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELOAD: begin
        if (tvalid_q && reload_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d     = CONFIG;
            cfg_valid_d = 1'b1;
          end
        end
        if ((!tvalid_q || reload_tready) && (ld_idx_q != NUM_TAPS_I)) begin
          tvalid_d = 1'b1;
          tdata_d  = buf_rd_data;
          tlast_d  = (ld_idx_q == LAST_IDX);
          ld_idx_d = ld_idx_q + 1'b1;
        end
      end
      CONFIG: begin
        if (cfg_valid_q && config_tready) begin
          state_d     = IDLE;
          cfg_valid_d = 1'b0;
          gate_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      cfg_valid_d = 1'b0;
      gate_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_comb begin
    err_set              = '0;
    err_set[ERR_TLAST]   = evt_tlast_miss | evt_tlast_unex;
    err_set[ERR_WR_BUSY] = coef_wr_en & busy;
    err_set[ERR_REQ_OVR] = reload_req & busy;
    err_set[ERR_TIMEOUT] = timeout;
    err_d                = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clkfir) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_idx_q    <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      cfg_valid_q <= 1'b0;
      gate_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_idx_q    <= ld_idx_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      cfg_valid_q <= cfg_valid_d;
      gate_q      <= gate_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign reload_tvalid = tvalid_q;
  assign reload_tlast  = tlast_q;
  assign reload_tdata  = tdata_q;
  assign config_tvalid = cfg_valid_q;
  assign config_tdata  = CONFIG_WORD;
  assign data_gate     = gate_q;
  assign done          = done_q;
  assign err_flags     = err_q;

endmodule
